// File: rtl/uart_cfg_master_pkg.sv
// Shared constants and state type for the UART configuration master:
// 16550-style register addresses, LSR/LCR bit positions, FSM states.
package uart_cfg_pkg;

  localparam logic [2:0] RBR_THR_DLL = 3'd0;
  localparam logic [2:0] IER_DLM     = 3'd1;
  localparam logic [2:0] IIR_FCR     = 3'd2;
  localparam logic [2:0] LCR         = 3'd3;
  localparam logic [2:0] LSR         = 3'd5;

  localparam int unsigned LSR_THRE = 5;
  localparam int unsigned DLAB_BIT = 7;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LCR_DLAB,
    S_DLL,
    S_DLM,
    S_LCR,
    S_FCR,
    S_IER,
    S_READY,
    S_RD_LSR,
    S_GAP,
    S_THR,
    S_ERR
  } state_t;

endpackage

// File: rtl/uart_cfg_master_if.sv
// Wishbone link between the configuration master and the UART register file.
// Signal names follow the UART's own port names (_i = into UART, _o = out of UART).
interface uart_cfg_master_if;
  logic [2:0] wb_addr_i;
  logic [7:0] wb_dat_i;
  logic [7:0] wb_dat_o;
  logic [3:0] wb_sel_i;
  logic       wb_we_i;
  logic       wb_stb_i;
  logic       wb_cyc_i;
  logic       wb_ack_o;

  modport master (
    output wb_addr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_addr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/uart_cfg_master_wb_xfer.sv
// Single non-pipelined Wishbone transfer engine: request/done handshake,
// read-data capture on the ack edge and an ack timeout.
module wb_xfer #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_req,
  input  logic [2:0]         i_addr,
  input  logic [7:0]         i_dat,
  input  logic               i_we,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_timeout,
  output logic [7:0]         o_rdata,
  uart_cfg_master_if.master  wb
);

  localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  logic             r_cyc;
  logic             r_we;
  logic [2:0]       r_addr;
  logic [7:0]       r_dat;
  logic [7:0]       r_rdata;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             r_tmo;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_dat   <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_tmo  <= 1'b0;
      if (r_cyc) begin
        // ack outranks a timeout landing on the same edge
        if (wb.wb_ack_o) begin
          r_cyc  <= 1'b0;
          r_we   <= 1'b0;
          r_done <= 1'b1;
          if (!r_we) r_rdata <= wb.wb_dat_o;
        end else if (r_cnt == CNT_LAST) begin
          r_cyc <= 1'b0;
          r_we  <= 1'b0;
          r_tmo <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else if (i_req) begin
        r_cyc  <= 1'b1;
        r_we   <= i_we;
        r_addr <= i_addr;
        r_dat  <= i_dat;
        r_cnt  <= '0;
      end
    end
  end

  assign o_busy    = r_cyc;
  assign o_done    = r_done;
  assign o_timeout = r_tmo;
  assign o_rdata   = r_rdata;

  assign wb.wb_cyc_i  = r_cyc;
  assign wb.wb_stb_i  = r_cyc;
  assign wb.wb_we_i   = r_we;
  assign wb.wb_addr_i = r_addr;
  assign wb.wb_dat_i  = r_dat;
  assign wb.wb_sel_i  = 4'b0001;

endmodule

// File: rtl/uart_cfg_master.sv
// Programs a 16550-style UART over Wishbone (divisor, line format, FIFO, IER),
// then forwards transmit bytes, polling LSR.THRE before each THR write.
module uart_cfg_master
  import uart_cfg_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned POLL_GAP    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       divisor,
  input  logic [7:0]        lcr_cfg,
  input  logic [7:0]        fcr_cfg,
  input  logic [7:0]        ier_cfg,
  input  logic              tx_valid,
  input  logic [7:0]        tx_data,
  output logic              tx_ready,
  output logic              cfg_done,
  output logic              error,
  uart_cfg_master_if.master wb
);

  localparam int unsigned GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

  state_t           r_state;
  logic [15:0]      r_div;
  logic [7:0]       r_lcr;
  logic [7:0]       r_fcr;
  logic [7:0]       r_ier;
  logic [7:0]       r_tx;
  logic [GAP_W-1:0] r_gap;

  state_t     w_next;
  state_t     w_after;
  logic       w_accept;
  logic       w_tx_hs;
  logic       w_xfer_st;
  logic       w_req;
  logic [2:0] w_addr;
  logic [7:0] w_dat;
  logic       w_we;
  logic       w_busy;
  logic       w_done;
  logic       w_tmo;
  logic [7:0] w_rdata;

  wb_xfer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_xfer (
    .clk       (clk),
    .rst       (rst),
    .i_req     (w_req),
    .i_addr    (w_addr),
    .i_dat     (w_dat),
    .i_we      (w_we),
    .o_busy    (w_busy),
    .o_done    (w_done),
    .o_timeout (w_tmo),
    .o_rdata   (w_rdata),
    .wb        (wb)
  );

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_READY));
  // start has priority in READY, so a coincident tx byte is not taken
  assign tx_ready = (r_state == S_READY) && !start;
  assign w_tx_hs  = tx_valid && tx_ready;
  assign cfg_done = (r_state == S_READY);
  assign error    = (r_state == S_ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_lcr   <= '0;
      r_fcr   <= '0;
      r_ier   <= '0;
      r_tx    <= '0;
      r_gap   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_div <= divisor;
        r_lcr <= lcr_cfg;
        r_fcr <= fcr_cfg;
        r_ier <= ier_cfg;
      end
      if (w_tx_hs) r_tx <= tx_data;
      r_gap <= ((r_state == S_GAP) && (w_next == S_GAP)) ? r_gap + 1'b1 : '0;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_after   = r_state;
    w_xfer_st = 1'b0;
    w_addr    = '0;
    w_dat     = '0;
    w_we      = 1'b0;
    unique case (r_state)
      S_IDLE: if (w_accept) w_next = S_LCR_DLAB;
      S_LCR_DLAB: begin
        w_xfer_st         = 1'b1;
        w_addr            = LCR;
        w_dat             = r_lcr;
        w_dat[DLAB_BIT]   = 1'b1;
        w_we              = 1'b1;
        w_after           = S_DLL;
      end
      S_DLL: begin
        w_xfer_st = 1'b1;
        w_addr    = RBR_THR_DLL;
        w_dat     = r_div[7:0];
        w_we      = 1'b1;
        w_after   = S_DLM;
      end
      S_DLM: begin
        w_xfer_st = 1'b1;
        w_addr    = IER_DLM;
        w_dat     = r_div[15:8];
        w_we      = 1'b1;
        w_after   = S_LCR;
      end
      S_LCR: begin
        w_xfer_st         = 1'b1;
        w_addr            = LCR;
        w_dat             = r_lcr;
        w_dat[DLAB_BIT]   = 1'b0;
        w_we              = 1'b1;
        w_after           = S_FCR;
      end
      S_FCR: begin
        w_xfer_st = 1'b1;
        w_addr    = IIR_FCR;
        w_dat     = r_fcr;
        w_we      = 1'b1;
        w_after   = S_IER;
      end
      S_IER: begin
        w_xfer_st = 1'b1;
        w_addr    = IER_DLM;
        w_dat     = r_ier;
        w_we      = 1'b1;
        w_after   = S_READY;
      end
      S_READY: begin
        if (w_accept)     w_next = S_LCR_DLAB;
        else if (w_tx_hs) w_next = S_RD_LSR;
      end
      S_RD_LSR: begin
        w_xfer_st = 1'b1;
        w_addr    = LSR;
        w_after   = w_rdata[LSR_THRE] ? S_THR : S_GAP;
      end
      S_GAP: if (r_gap == GAP_LAST) w_next = S_RD_LSR;
      S_THR: begin
        w_xfer_st = 1'b1;
        w_addr    = RBR_THR_DLL;
        w_dat     = r_tx;
        w_we      = 1'b1;
        w_after   = S_READY;
      end
      S_ERR: w_next = S_ERR;
      default: w_next = S_IDLE;
    endcase

    // one request per state visit: issue on entry, advance on the done/timeout pulse
    w_req = w_xfer_st && !w_busy && !w_done && !w_tmo;
    if (w_xfer_st) begin
      if (w_tmo)       w_next = S_ERR;
      else if (w_done) w_next = w_after;
    end
  end

endmodule

// File: tb/tb_uart_cfg_master.sv
// Directed bench for uart_cfg_master: Wishbone slave model with per-transfer ack
// delay and LSR read data, plus an expected-transfer scoreboard.
module tb_uart_cfg_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] divisor = '0;
  logic [7:0]  lcr_cfg = '0;
  logic [7:0]  fcr_cfg = '0;
  logic [7:0]  ier_cfg = '0;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data = '0;
  logic        tx_ready;
  logic        cfg_done;
  logic        error;

  uart_cfg_master_if wb ();

  uart_cfg_master #(
    .ACK_TIMEOUT(16),
    .POLL_GAP   (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .divisor  (divisor),
    .lcr_cfg  (lcr_cfg),
    .fcr_cfg  (fcr_cfg),
    .ier_cfg  (ier_cfg),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .cfg_done (cfg_done),
    .error    (error),
    .wb       (wb)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [11:0] exp_q[$];   // {we, addr, dat}
  logic [7:0]  lsr_q[$];
  int unsigned rd_start[$];
  int unsigned rd_end[$];
  int unsigned cyc_cnt = 0;
  int unsigned xfer_idx = 0;
  int unsigned slow_nth = 0;
  int unsigned ack_wait = 0;
  bit          ack_en = 1'b1;
  logic        prev_cyc = 1'b0;
  logic [11:0] cur = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, then monitor the bus and drive the slave response.
  task automatic tick();
    logic [11:0] obs;
    logic [11:0] e;
    int unsigned dly;
    @(negedge clk);
    cyc_cnt++;
    obs = {wb.wb_we_i, wb.wb_addr_i, wb.wb_dat_i};
    if (wb.wb_cyc_i && !prev_cyc) begin
      xfer_idx++;
      ack_wait = 0;
      cur = obs;
      check("stb_with_cyc", {31'd0, wb.wb_stb_i}, 32'd1);
      check("xfer_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("xfer_we_addr_dat", {20'd0, obs}, {20'd0, e});
      end
      if (!wb.wb_we_i) rd_start.push_back(cyc_cnt);
    end else if (wb.wb_cyc_i) begin
      check("hold_stable", {20'd0, obs}, {20'd0, cur});
    end
    if (!wb.wb_cyc_i && prev_cyc && !cur[11]) rd_end.push_back(cyc_cnt);

    wb.wb_ack_o = 1'b0;
    if (wb.wb_cyc_i) begin
      ack_wait++;
      dly = (xfer_idx == slow_nth) ? 5 : 1;
      if (ack_en && ack_wait == dly) begin
        wb.wb_ack_o = 1'b1;
        if (!wb.wb_we_i) begin
          if (lsr_q.size() != 0) wb.wb_dat_o = lsr_q.pop_front();
          else                   wb.wb_dat_o = 8'h60;
        end
      end
    end
    prev_cyc = wb.wb_cyc_i;
  endtask

  task automatic push_cfg1();
    exp_q.push_back({1'b1, 3'd3, 8'h83});
    exp_q.push_back({1'b1, 3'd0, 8'h45});
    exp_q.push_back({1'b1, 3'd1, 8'h01});
    exp_q.push_back({1'b1, 3'd3, 8'h03});
    exp_q.push_back({1'b1, 3'd2, 8'hC7});
    exp_q.push_back({1'b1, 3'd1, 8'h01});
  endtask

  task automatic start_cfg(input logic [15:0] d, input logic [7:0] l, input logic [7:0] f,
                           input logic [7:0] i);
    divisor = d; lcr_cfg = l; fcr_cfg = f; ier_cfg = i;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int unsigned n;
    n = 0;
    while (!(cfg_done && exp_q.size() == 0) && n < 400) begin tick(); n++; end
    check(tag, {31'd0, cfg_done}, 32'd1);
    check({tag, "_all_xfers"}, exp_q.size(), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned n;
    tx_valid = 1'b1;
    tx_data  = b;
    tick();
    tx_valid = 1'b0;
    tx_data  = '0;
    check("tx_ready_low_busy", {31'd0, tx_ready}, 32'd0);
    n = 0;
    while ((exp_q.size() != 0 || !tx_ready) && n < 400) begin tick(); n++; end
    check("tx_all_xfers", exp_q.size(), 32'd0);
    check("tx_ready_again", {31'd0, tx_ready}, 32'd1);
  endtask

  initial begin
    int unsigned n;
    int unsigned high;
    wb.wb_ack_o = 1'b0;
    wb.wb_dat_o = 8'h00;

    // reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst_cyc", {31'd0, wb.wb_cyc_i}, 32'd0);
    check("rst_stb", {31'd0, wb.wb_stb_i}, 32'd0);
    check("rst_we", {31'd0, wb.wb_we_i}, 32'd0);
    check("rst_addr", {29'd0, wb.wb_addr_i}, 32'd0);
    check("rst_dat", {24'd0, wb.wb_dat_i}, 32'd0);
    check("rst_sel", {28'd0, wb.wb_sel_i}, 32'd1);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
    check("rst_cfg_done", {31'd0, cfg_done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    rst = 1'b0;
    tick();

    // configuration sequence
    push_cfg1();
    start_cfg(16'h0145, 8'h03, 8'hC7, 8'h01);
    wait_ready("cfg1_done");
    check("cfg1_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("cfg1_error", {31'd0, error}, 32'd0);

    // transmit with THRE already set
    rd_start.delete(); rd_end.delete();
    lsr_q.push_back(8'h60);
    exp_q.push_back({1'b0, 3'd5, 8'h00});
    exp_q.push_back({1'b1, 3'd0, 8'h5A});
    send_byte(8'h5A);
    check("tx_lsr_reads", rd_start.size(), 32'd1);

    // busy poll: two busy LSR reads, then THRE
    rd_start.delete(); rd_end.delete();
    lsr_q.push_back(8'h00); lsr_q.push_back(8'h00); lsr_q.push_back(8'h20);
    repeat (3) exp_q.push_back({1'b0, 3'd5, 8'h00});
    exp_q.push_back({1'b1, 3'd0, 8'hC3});
    send_byte(8'hC3);
    check("poll_lsr_reads", rd_start.size(), 32'd3);
    if (rd_start.size() == 3 && rd_end.size() >= 2) begin
      for (int i = 1; i < 3; i++)
        check("poll_gap_ge_4", {31'd0, (rd_start[i] - rd_end[i-1]) >= 4}, 32'd1);
    end

    // slow ack on DLM, start during the sequence ignored, LCR bit7 ignored
    xfer_idx = 0;
    slow_nth = 3;
    exp_q.push_back({1'b1, 3'd3, 8'h9B});
    exp_q.push_back({1'b1, 3'd0, 8'h34});
    exp_q.push_back({1'b1, 3'd1, 8'h12});
    exp_q.push_back({1'b1, 3'd3, 8'h1B});
    exp_q.push_back({1'b1, 3'd2, 8'h07});
    exp_q.push_back({1'b1, 3'd1, 8'h0F});
    start_cfg(16'h1234, 8'h9B, 8'h07, 8'h0F);
    check("cfg_done_falls", {31'd0, cfg_done}, 32'd0);
    n = 0;
    while (!(wb.wb_cyc_i && wb.wb_addr_i == 3'd1) && n < 100) begin tick(); n++; end
    check("slow_dlm_seen", {31'd0, wb.wb_cyc_i}, 32'd1);
    start_cfg(16'hFFFF, 8'h1F, 8'hFF, 8'hFF);
    wait_ready("slow_done");
    check("slow_error", {31'd0, error}, 32'd0);
    slow_nth = 0;

    // reset in the middle of the FCR write, then a full rerun
    push_cfg1();
    start_cfg(16'h0145, 8'h03, 8'hC7, 8'h01);
    n = 0;
    while (!(wb.wb_cyc_i && wb.wb_addr_i == 3'd2) && n < 100) begin tick(); n++; end
    check("fcr_reached", {31'd0, wb.wb_cyc_i}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_cyc", {31'd0, wb.wb_cyc_i}, 32'd0);
    check("midrst_cfg_done", {31'd0, cfg_done}, 32'd0);
    check("midrst_tx_ready", {31'd0, tx_ready}, 32'd0);
    check("midrst_ier_skipped", exp_q.size(), 32'd1);
    exp_q.delete();
    repeat (2) tick();
    check("midrst_idle", {31'd0, wb.wb_cyc_i}, 32'd0);
    push_cfg1();
    start_cfg(16'h0145, 8'h03, 8'hC7, 8'h01);
    wait_ready("rerun_done");

    // ack timeout, sticky error, start ignored in ERR
    ack_en = 1'b0;
    exp_q.push_back({1'b1, 3'd3, 8'h83});
    start_cfg(16'h0145, 8'h03, 8'hC7, 8'h01);
    n = 0;
    while (!wb.wb_cyc_i && n < 20) begin tick(); n++; end
    high = 0;
    while (wb.wb_cyc_i && high < 100) begin high++; tick(); end
    check("timeout_wait_cycles", high, 32'd16);
    repeat (3) tick();
    check("timeout_error", {31'd0, error}, 32'd1);
    check("timeout_cfg_done", {31'd0, cfg_done}, 32'd0);
    check("timeout_tx_ready", {31'd0, tx_ready}, 32'd0);
    start_cfg(16'h0145, 8'h03, 8'hC7, 8'h01);
    repeat (30) tick();
    check("err_start_ignored_cyc", {31'd0, wb.wb_cyc_i}, 32'd0);
    check("err_sticky", {31'd0, error}, 32'd1);
    check("err_no_xfers_left", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
